// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the sequential restoring divider.
//   - div_state_e : controller state encoding (IDLE / BUSY / DONE)
//   - div_clog2   : ceil(log2(v)), used to size the step counter
//                   (the counter holds values 0..N, so it is sized with N+1)
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Constant function, evaluated at elaboration only. Returns at least 1.
  function automatic int div_clog2(input int unsigned v);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'd1 << i) < v) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
// The partial remainder is shifted left by one bit, with the next dividend
// bit (the msb of Q) entering at the bottom. The divisor is then trial-
// subtracted from it. If the result is non-negative, it becomes the new
// remainder and the quotient bit is 1. Otherwise, the shifted value is kept
// and the quotient bit is 0.
// Ports:
//   r_i       [N:0]   current partial remainder
//   q_msb_i           dividend bit shifted in this step (Q msb)
//   divisor_i [N-1:0] divisor
//   r_o       [N:0]   next partial remainder
//   q_bit_o           quotient bit produced by this step
module div_step
  import div_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N:0]   r_i,
  input  logic         q_msb_i,
  input  logic [N-1:0] divisor_i,
  output logic [N:0]   r_o,
  output logic         q_bit_o
);

  logic [N:0]   shifted;
  logic [N+1:0] trial;

  always_comb begin
    shifted = {r_i[N-1:0], q_msb_i};
    trial   = {1'b0, shifted} - {2'b00, divisor_i};
    // A set r_i[N] means the true shifted value is at least 2^(N+1), which
    // always exceeds the divisor. In that case, the subtraction cannot go
    // negative. This only occurs on operations already flagged as overflow,
    // whose remainder is discarded.
    q_bit_o = r_i[N] | ~trial[N+1];
    r_o     = q_bit_o ? trial[N:0] : shifted;
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider, 2N-bit / N-bit.
// It produces one quotient bit per clock and uses a valid/ready handshake on
// both the input and output sides.
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   in_valid / in_ready       operation handshake (ready only in IDLE)
//   dividend [2N-1:0]         unsigned dividend, sampled at the accepting edge
//   divisor  [N-1:0]          unsigned divisor, sampled at the accepting edge
//   out_valid / out_ready     result handshake
//   quotient, remainder [N-1:0]
//   overflow                  quotient does not fit in N bits (includes /0)
//   div_by_zero               divisor was zero
// Build option:
//   DIV_FAST_OVF_EN  When this macro is defined, operations that overflow go
//                    straight from IDLE to DONE. When it is undefined, every
//                    operation takes the same latency. Output values are the
//                    same in both builds.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           overflow,
  output logic           div_by_zero
);

  localparam int CW = div_clog2(N + 1);

  div_state_e    state_q;
  logic [N:0]    r_q;
  logic [N-1:0]  q_q;
  logic [N-1:0]  div_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          dz_q;

  logic          out_valid_q;
  logic [N-1:0]  quotient_q;
  logic [N-1:0]  remainder_q;
  logic          overflow_q;
  logic          div_by_zero_q;

  logic [N:0]    r_d;
  logic          q_bit_d;
  logic [N-1:0]  q_d;
  logic          accept;
  logic          ovf_now;
  logic          dz_now;

  div_step #(.N(N)) u_step (
    .r_i       (r_q),
    .q_msb_i   (q_q[N-1]),
    .divisor_i (div_q),
    .r_o       (r_d),
    .q_bit_o   (q_bit_d)
  );

  always_comb begin
    q_d      = {q_q[N-2:0], q_bit_d};
    in_ready = (state_q == IDLE) & ~rst;
    accept   = in_valid & in_ready;
    // The quotient fits in N bits only if the upper dividend half is
    // strictly less than the divisor. A divisor of zero always fails this.
    ovf_now  = (dividend[2*N-1:N] >= divisor);
    dz_now   = (divisor == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      r_q           <= '0;
      q_q           <= '0;
      div_q         <= '0;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
      dz_q          <= 1'b0;
      out_valid_q   <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      overflow_q    <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            r_q   <= {1'b0, dividend[2*N-1:N]};
            q_q   <= dividend[N-1:0];
            div_q <= divisor;
            ovf_q <= ovf_now;
            dz_q  <= dz_now;
            cnt_q <= CW'(N);
`ifdef DIV_FAST_OVF_EN
            if (ovf_now) begin
              // The result is already known to be saturated, so the
              // iterations are skipped.
              state_q       <= DONE;
              cnt_q         <= '0;
              out_valid_q   <= 1'b1;
              quotient_q    <= '1;
              remainder_q   <= '0;
              overflow_q    <= 1'b1;
              div_by_zero_q <= dz_now;
            end else begin
              state_q <= BUSY;
            end
`else
            state_q <= BUSY;
`endif
          end
        end

        BUSY: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            // The last step's results go directly to the outputs, so the
            // result is ready without waiting an extra cycle.
            state_q       <= DONE;
            out_valid_q   <= 1'b1;
            quotient_q    <= ovf_q ? '1 : q_d;
            remainder_q   <= ovf_q ? '0 : r_d[N-1:0];
            overflow_q    <= ovf_q;
            div_by_zero_q <= dz_q;
          end
        end

        DONE: begin
          if (out_ready) begin
            // Quotient and remainder keep their last value; only the flags
            // are cleared.
            state_q       <= IDLE;
            out_valid_q   <= 1'b0;
            overflow_q    <= 1'b0;
            div_by_zero_q <= 1'b0;
          end
        end

        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign overflow    = overflow_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential unsigned restoring divider; the inverse of the codebase's combinational N×N multiplier.
- Accepts a 2N-bit dividend (a product) and an N-bit divisor.
- Returns an N-bit quotient and an N-bit remainder, one quotient bit per clock.
- Used in the DSP datapath for normalisation and gain recovery; valid/ready handshake on both input and output sides.

Parameters:
- N, 4, operand width; dividend is 2N bits, divisor/quotient/remainder are N bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  dividend/divisor valid.
- in_ready  output  1  block can accept an operation.
- dividend  input  2N  unsigned dividend.
- divisor  input  N  unsigned divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  N  unsigned quotient.
- remainder  output  N  unsigned remainder.
- overflow  output  1  quotient does not fit in N bits (includes divide-by-zero).
- div_by_zero  output  1  divisor was zero.

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE; out_valid, quotient, remainder, overflow, div_by_zero all 0; internal counter 0. in_ready is 0 while rst is high, then 1 in IDLE.
- in_ready = (state==IDLE) & ~rst, purely from state. out_valid = (state==DONE), registered.
- States: IDLE, BUSY, DONE.
- IDLE -> BUSY on in_valid & in_ready.
  - Capture R(N+1 bits) = {0, dividend[2N-1:N]}, Q = dividend[N-1:0] and divisor.
  - Set ovf_int = (dividend[2N-1:N] >= divisor).
  - Set dz = (divisor==0).
  - Counter = N.
- BUSY, each cycle:
  - Shift {R,Q} left by 1.
  - Trial T = R - {0,divisor}.
  - If T is non-negative, R=T and Q[0]=1; else Q[0]=0.
  - Decrement counter.
  - When counter reaches 1 and the step completes, go to DONE.
  - BUSY lasts exactly N cycles; out_valid is first high N+1 cycles after the accepting edge.
- Entering DONE:
  - quotient = ovf_int ? all-ones : Q.
  - remainder = ovf_int ? 0 : R[N-1:0].
  - overflow = ovf_int; div_by_zero = dz.
- DONE: outputs held stable while out_ready=0. On out_ready=1, go to IDLE and clear out_valid. Data outputs keep their last value; flags are cleared.
- No new operation is accepted in the same cycle a result is consumed. Maximum throughput is one operation per N+2 cycles.
- in_valid is ignored outside IDLE. dividend/divisor are sampled only at the accepting edge and may change afterwards.
- Non-overflow case: the remainder never exceeds N bits, and quotient*divisor + remainder == dividend exactly.
- Reset mid-BUSY or mid-DONE: aborts immediately to IDLE, the pending result is discarded, and no out_valid pulse appears.

Optional Feature:
- Macro: DIV_FAST_OVF_EN.
- Defined: on accept with ovf_int=1, go IDLE -> DONE directly, skipping BUSY. out_valid is high 1 cycle after the accepting edge with saturated outputs.
- Undefined: overflow operations still spend N cycles in BUSY, giving constant latency. Output values are identical in both builds.

Decomposition:
- Shared package div_pkg: state enum (IDLE/BUSY/DONE) and the counter width function clog2(N+1).
- One natural sub-module, div_step: a combinational single restoring step.
  - Inputs: R, Q msb, divisor.
  - Outputs: next R, quotient bit.
- Control FSM and registers stay in seq_divider.

Test Plan:
- N=4, dividend=8'h8F (143), divisor=4'hB -> after N=4 BUSY cycles: quotient=4'hD, remainder=0, overflow=0; out_valid first high 5 cycles after accept.
- dividend=8'd100, divisor=4'd7 -> quotient=4'd14, remainder=4'd2, flags 0.
- dividend=8'hF0, divisor=4'h3 -> overflow=1, quotient=4'hF, remainder=0. out_valid arrives after 5 cycles (macro off) or 1 cycle (DIV_FAST_OVF_EN).
- divisor=0, dividend=8'h12 -> overflow=1, div_by_zero=1, quotient=4'hF, remainder=0.
- Backpressure: hold out_ready=0 for 6 cycles in DONE -> outputs stable and in_ready=0 throughout. in_valid pulses during BUSY/DONE are ignored. Release out_ready -> IDLE next cycle.
- Assert rst for 1 cycle during the 2nd BUSY cycle -> out_valid never rises and in_ready=1 the cycle after rst drops. The next operation (8'd50/4'd5) returns quotient=4'd10, remainder=0.
